// File: rtl/if_pc_unit.sv
// Program counter and fetch-redirect unit: picks the next fetch address and
// drives pipeline flush/hold controls. It also latches the trap return address.
module if_pc_unit #(
   parameter logic [31:0] RESET_VEC = 32'h8000_0000,
   parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
   parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        EX_Branch_EN,
   input  logic [31:0] ConBA,
   input  logic        id_jump,
   input  logic        id_jr,
   input  logic [25:0] id_jt,
   input  logic [31:0] id_jr_target,
   input  logic [31:0] id_pc,
   input  logic        id_exception,
   input  logic        irq,
   output logic [31:0] pc,
   output logic [31:0] pc_plus_4,
   output logic [31:0] epc,
   output logic        flush_if_id,
   output logic        hold_if_id,
   output logic        flush_id_ex
);

   localparam int unsigned AW = 32;

   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] epc_q, epc_d;
   logic          irq_pending_q, irq_pending_d;
   logic          irq_s1_q, irq_s2_q, irq_s3_q;
   logic          irq_rise;
   logic          int_take;
   logic          int_clr;
   logic          trap;

   assign pc_plus_4 = pc_q + AW'(4);

   // Trap/interrupt qualification and next-PC selection
   always_comb begin
      irq_rise      = irq_s2_q & ~irq_s3_q;
      int_take      = irq_pending_q & ~pc_q[AW-1] & ~EX_Branch_EN;
      trap          = (id_exception | int_take) & ~EX_Branch_EN;
      // an undefined instruction outranks the interrupt, which then stays pending
      int_clr       = int_take & ~id_exception;
      irq_pending_d = (irq_pending_q & ~int_clr) | irq_rise;
      pc_d          = pc_plus_4;
      epc_d         = epc_q;
      if (EX_Branch_EN) begin
         pc_d = ConBA;
      end else if (trap) begin
         pc_d  = id_exception ? ILLOP_VEC : XADR_VEC;
         epc_d = id_pc;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (id_jr) begin
         pc_d = {pc_q[AW-1] & id_jr_target[AW-1], id_jr_target[AW-2:0]};
      end else if (id_jump) begin
         pc_d = {id_pc[31:28], id_jt, 2'b00};
      end
   end

   assign flush_if_id = EX_Branch_EN | trap | (~stall & (id_jr | id_jump));
   assign flush_id_ex = EX_Branch_EN | trap | stall;
   assign hold_if_id  = stall & ~EX_Branch_EN & ~trap;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q          <= RESET_VEC;
         epc_q         <= '0;
         irq_pending_q <= 1'b0;
         irq_s1_q      <= 1'b0;
         irq_s2_q      <= 1'b0;
         irq_s3_q      <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         epc_q         <= epc_d;
         irq_pending_q <= irq_pending_d;
         irq_s1_q      <= irq;
         irq_s2_q      <= irq_s1_q;
         irq_s3_q      <= irq_s2_q;
      end
   end

   assign pc  = pc_q;
   assign epc = epc_q;

endmodule

// File: tb/tb_if_pc_unit.sv
// Self-checking bench for if_pc_unit: directed vector table, hand-written
// interrupt/collision/reset sequences, then random stimulus against a model.
module tb_if_pc_unit;

   localparam logic [31:0] RST_V = 32'h8000_0000;
   localparam logic [31:0] ILL_V = 32'h8000_0004;
   localparam logic [31:0] XAD_V = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0, br = 1'b0, jump = 1'b0, jr = 1'b0, exc = 1'b0, irq = 1'b0;
   logic [31:0] conba = '0, jrt = '0, idpc = '0;
   logic [25:0] jt = '0;
   logic [31:0] pc, pc_plus_4, epc;
   logic        flush_if_id, hold_if_id, flush_id_ex;

   int checks = 0;
   int errors = 0;

   if_pc_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .EX_Branch_EN(br), .ConBA(conba),
      .id_jump(jump), .id_jr(jr), .id_jt(jt), .id_jr_target(jrt), .id_pc(idpc),
      .id_exception(exc), .irq(irq), .pc(pc), .pc_plus_4(pc_plus_4), .epc(epc),
      .flush_if_id(flush_if_id), .hold_if_id(hold_if_id), .flush_id_ex(flush_id_ex)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        stall, br;
      logic [31:0] conba;
      logic        jump, jr;
      logic [25:0] jt;
      logic [31:0] jrt, idpc;
      logic        exc;
      logic [31:0] exp_pc, exp_epc;
      logic        f_ifid, hold, f_idex;
   } vec_t;

   vec_t vt[18];

   function automatic vec_t mk(input logic s, input logic b, input logic [31:0] cb,
                               input logic j, input logic r, input logic [25:0] t,
                               input logic [31:0] rt, input logic [31:0] ip, input logic e,
                               input logic [31:0] ep, input logic [31:0] ee,
                               input logic fi, input logic h, input logic fx);
      vec_t v;
      v.stall = s; v.br = b; v.conba = cb; v.jump = j; v.jr = r; v.jt = t;
      v.jrt = rt; v.idpc = ip; v.exc = e; v.exp_pc = ep; v.exp_epc = ee;
      v.f_ifid = fi; v.hold = h; v.f_idex = fx;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      stall = 0; br = 0; jump = 0; jr = 0; exc = 0;
      conba = '0; jrt = '0; jt = '0;
   endtask

   task automatic chk_ctl(input string name, input logic fi, input logic h, input logic fx);
      chk({name, ".flush_if_id"}, 32'(flush_if_id), 32'(fi));
      chk({name, ".hold_if_id"},  32'(hold_if_id),  32'(h));
      chk({name, ".flush_id_ex"}, 32'(flush_id_ex), 32'(fx));
   endtask

   // random-phase reference state
   logic [31:0] m_pc, m_epc, np, ne;
   logic        m_pend, m_take, m_trap, m_rise;
   logic        hist[0:1023];
   bit          found;
   logic [31:0] prev_pc;

   initial begin
      //                 stall br conba         jump jr jt            jrt           idpc          exc exp_pc        exp_epc       fi h  fx
      vt[0]  = mk(0, 0, 32'h0,         0, 0, 26'h0,       32'h0,        32'h0,        0, 32'h8000_0004, 32'h0,    0, 0, 0);
      vt[1]  = mk(0, 1, 32'h0000_0040, 0, 0, 26'h0,       32'h0,        32'h0,        0, 32'h0000_0040, 32'h0,    1, 0, 1);
      vt[2]  = mk(0, 1, 32'h0000_0100, 1, 0, 26'h3,       32'h0,        32'h0,        0, 32'h0000_0100, 32'h0,    1, 0, 1);
      vt[3]  = mk(0, 1, 32'h0000_0010, 0, 0, 26'h0,       32'h0,        32'h0,        0, 32'h0000_0010, 32'h0,    1, 0, 1);
      vt[4]  = mk(0, 0, 32'h0,         0, 1, 26'h0,       32'h8000_0020, 32'h0,       0, 32'h0000_0020, 32'h0,    1, 0, 0);
      vt[5]  = mk(1, 0, 32'h0,         1, 0, 26'h100,     32'h0,        32'h0,        0, 32'h0000_0020, 32'h0,    0, 1, 1);
      vt[6]  = mk(1, 0, 32'h0,         1, 0, 26'h100,     32'h0,        32'h0,        0, 32'h0000_0020, 32'h0,    0, 1, 1);
      vt[7]  = mk(0, 0, 32'h0,         1, 0, 26'h100,     32'h0,        32'h0,        0, 32'h0000_0400, 32'h0,    1, 0, 0);
      vt[8]  = mk(0, 0, 32'h0,         0, 0, 26'h0,       32'h0,        32'h0,        0, 32'h0000_0404, 32'h0,    0, 0, 0);
      vt[9]  = mk(0, 0, 32'h0,         0, 0, 26'h0,       32'h0,        32'h0000_0400, 1, 32'h8000_0004, 32'h400, 1, 0, 1);
      vt[10] = mk(0, 0, 32'h0,         0, 1, 26'h0,       32'h8000_1000, 32'h0,       0, 32'h8000_1000, 32'h400,  1, 0, 0);
      vt[11] = mk(0, 0, 32'h0,         0, 1, 26'h0,       32'h0000_0300, 32'h0,       0, 32'h0000_0300, 32'h400,  1, 0, 0);
      vt[12] = mk(0, 1, 32'h0000_0500, 0, 0, 26'h0,       32'h0,        32'h0000_0999, 1, 32'h0000_0500, 32'h400, 1, 0, 1);
      vt[13] = mk(1, 0, 32'h0,         0, 0, 26'h0,       32'h0,        32'h0000_1230, 1, 32'h8000_0004, 32'h1230, 1, 0, 1);
      vt[14] = mk(1, 1, 32'hFFFF_FFFC, 0, 0, 26'h0,       32'h0,        32'h0,        0, 32'hFFFF_FFFC, 32'h1230, 1, 0, 1);
      vt[15] = mk(0, 0, 32'h0,         0, 0, 26'h0,       32'h0,        32'h0,        0, 32'h0000_0000, 32'h1230, 0, 0, 0);
      vt[16] = mk(0, 0, 32'h0,         1, 0, 26'h3FF_FFFF, 32'h0,       32'hA000_0000, 0, 32'hAFFF_FFFC, 32'h1230, 1, 0, 0);
      vt[17] = mk(1, 0, 32'h0,         0, 1, 26'h0,       32'h0000_0700, 32'h0,       0, 32'hAFFF_FFFC, 32'h1230, 0, 1, 1);

      // initial reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst.pc", pc, RST_V);
      chk("rst.epc", epc, 32'h0);
      @(posedge clk);
      #2 reset = 1;

      // directed table
      prev_pc = RST_V;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         stall = vt[i].stall; br = vt[i].br; conba = vt[i].conba; jump = vt[i].jump;
         jr = vt[i].jr; jt = vt[i].jt; jrt = vt[i].jrt; idpc = vt[i].idpc; exc = vt[i].exc;
         #1;
         chk_ctl($sformatf("vec%0d", i), vt[i].f_ifid, vt[i].hold, vt[i].f_idex);
         chk($sformatf("vec%0d.pc_plus_4", i), pc_plus_4, prev_pc + 32'd4);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d.pc", i), pc, vt[i].exp_pc);
         chk($sformatf("vec%0d.epc", i), epc, vt[i].exp_epc);
         prev_pc = vt[i].exp_pc;
      end

      // interrupt from user mode after synchronizer delay
      @(negedge clk); idle(); br = 1; conba = 32'h0000_0200;
      @(negedge clk); idle(); idpc = 32'h0000_01FC; irq = 1;
      chk("irq.start_pc", pc, 32'h0000_0200);
      @(negedge clk); irq = 0;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge clk);
         if (pc == XAD_V) found = 1;
      end
      chk("irq.taken_in_time", 32'(found), 32'd1);
      chk("irq.pc", pc, XAD_V);
      chk("irq.epc", epc, 32'h0000_01FC);

      // a new irq in kernel mode stays pending until user mode
      irq = 1;
      @(negedge clk); irq = 0;
      repeat (5) @(negedge clk);
      chk("irq.masked_pc", pc, 32'h8000_0020);
      jr = 1; jrt = 32'h0000_0600; idpc = 32'h0000_05FC;
      @(negedge clk);
      chk("irq.to_user_pc", pc, 32'h0000_0600);
      jr = 0;
      @(negedge clk);
      chk("irq.deferred_pc", pc, XAD_V);
      chk("irq.deferred_epc", epc, 32'h0000_05FC);

      // exception vs pending interrupt, then branch vs pending interrupt
      irq = 1;
      @(negedge clk); irq = 0;
      repeat (4) @(negedge clk);
      jr = 1; jrt = 32'h0000_0700;
      @(negedge clk);
      chk("coll.user_pc", pc, 32'h0000_0700);
      idle(); exc = 1; idpc = 32'h0000_06F0;
      #1;
      chk_ctl("coll.exc", 1, 0, 1);
      @(negedge clk);
      chk("coll.illop_pc", pc, ILL_V);
      chk("coll.illop_epc", epc, 32'h0000_06F0);
      idle(); jr = 1; jrt = 32'h0000_0800;
      @(negedge clk);
      chk("coll.user2_pc", pc, 32'h0000_0800);
      idle(); br = 1; conba = 32'h0000_0900; exc = 1; idpc = 32'h0000_08F0;
      #1;
      chk_ctl("coll.br", 1, 0, 1);
      @(negedge clk);
      chk("coll.br_pc", pc, 32'h0000_0900);
      chk("coll.br_epc", epc, 32'h0000_06F0);
      idle(); idpc = 32'h0000_08FC;
      @(negedge clk);
      chk("coll.pending_pc", pc, XAD_V);
      chk("coll.pending_epc", epc, 32'h0000_08FC);

      // asynchronous reset mid-cycle
      @(posedge clk);
      #3 reset = 0;
      #1;
      chk("mid_rst.pc", pc, RST_V);
      chk("mid_rst.epc", epc, 32'h0);
      @(negedge clk); idle(); idpc = '0; reset = 1;
      @(posedge clk);
      #1;
      chk("mid_rst.first_pc", pc, 32'h8000_0004);

      // random phase against a spec-level model
      m_pc = 32'h8000_0004; m_epc = '0; m_pend = 0;
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 9) == 0) irq = ~irq;
         br    = ($urandom_range(0, 99) < 12);
         conba = {($urandom_range(0, 2) == 0), 29'($urandom), 2'b00};
         exc   = ($urandom_range(0, 99) < 5);
         stall = ($urandom_range(0, 99) < 20);
         jr    = ($urandom_range(0, 99) < 15);
         jump  = ($urandom_range(0, 99) < 15);
         jt    = 26'($urandom);
         jrt   = $urandom;
         idpc  = $urandom;
         hist[n] = irq;
         #1;
         m_take = m_pend & ~m_pc[31] & ~br;
         m_trap = (exc | m_take) & ~br;
         chk_ctl($sformatf("rnd%0d", n), br | m_trap | (~stall & (jr | jump)),
                 stall & ~br & ~m_trap, br | m_trap | stall);
         chk($sformatf("rnd%0d.pc_plus_4", n), pc_plus_4, m_pc + 32'd4);
         ne = m_epc;
         if (br) np = conba;
         else if (m_trap) begin np = exc ? ILL_V : XAD_V; ne = idpc; end
         else if (stall) np = m_pc;
         else if (jr) np = {m_pc[31] & jrt[31], jrt[30:0]};
         else if (jump) np = {idpc[31:28], jt, 2'b00};
         else np = m_pc + 32'd4;
         // a rise sampled two edges back reaches the pending latch on this edge
         m_rise = (n >= 2 ? hist[n-2] : 1'b0) & ~(n >= 3 ? hist[n-3] : 1'b0);
         m_pend = m_rise | (m_pend & ~(m_take & ~exc));
         m_pc = np; m_epc = ne;
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d.pc", n), pc, m_pc);
         chk($sformatf("rnd%0d.epc", n), epc, m_epc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_pc_unit.md
# if_pc_unit

Program-counter and fetch-redirect unit for the five-stage pipelined CPU. Holds the PC register and selects the next fetch address from four sources: sequential PC+4, a taken conditional branch resolved in EX (`EX_Branch_EN`/`ConBA`), a J/JR jump decoded in ID, or a trap vector. It drives the IF/ID and ID/EX flush/hold controls and latches the exception return address. It is the consumer of the EX stage's branch outputs; the EX stage computes branch targets, and this block acts on them.

## Interface
Parameters:
- RESET_VEC, 32'h8000_0000, PC value after reset (kernel mode)
- ILLOP_VEC, 32'h8000_0004, entry for an undefined instruction in ID
- XADR_VEC, 32'h8000_0008, entry for an external interrupt

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; one clock; reset polarity and synchronicity are fixed
- stall  in  1  load-use hazard from the hazard unit; hold PC and IF/ID
- EX_Branch_EN  in  1  conditional branch in EX is taken
- ConBA  in  32  branch target from EX
- id_jump  in  1  J/JAL in ID
- id_jr  in  1  JR/JALR in ID
- id_jt  in  26  jump field of the ID instruction
- id_jr_target  in  32  forwarded rs value for JR
- id_pc  in  32  PC of the ID instruction
- id_exception  in  1  undefined opcode in ID
- irq  in  1  asynchronous external interrupt request, level
- pc  out  32  current fetch address (registered)
- pc_plus_4  out  32  pc + 4
- epc  out  32  return address of the last trap (registered)
- flush_if_id  out  1  squash the IF/ID register next edge
- hold_if_id  out  1  keep IF/ID unchanged next edge
- flush_id_ex  out  1  insert a bubble into ID/EX next edge

## Operation
- Kernel mode is `pc[31]`.
- irq path: two-flop synchronizer, then rising-edge detect. The detected edge sets `irq_pending`. `irq_pending` is cleared only when the interrupt is taken.
- Interrupt taken: `int_take = irq_pending & ~pc[31] & ~EX_Branch_EN`. Interrupts are masked in kernel mode; the pending bit is held until the CPU returns to user mode.
- Trap taken: `trap = (id_exception | int_take) & ~EX_Branch_EN`.
- Next-PC priority, highest first:
  1. EX_Branch_EN: `pc <= ConBA`.
  2. trap: `pc <= ILLOP_VEC` if id_exception, else XADR_VEC. id_exception wins over an interrupt in the same cycle; the interrupt stays pending. `epc <= id_pc`.
  3. stall: `pc <= pc`.
  4. id_jr: `pc <= {pc[31] & id_jr_target[31], id_jr_target[30:0]}`. User mode cannot enter kernel via JR.
  5. id_jump: `pc <= {id_pc[31:28], id_jt, 2'b00}`.
  6. Otherwise: `pc <= pc_plus_4`.
- Control outputs (combinational from current inputs and state):
  - `flush_if_id = EX_Branch_EN | trap | (~stall & (id_jr | id_jump))`
  - `flush_id_ex = EX_Branch_EN | trap | stall`
  - `hold_if_id = stall & ~EX_Branch_EN & ~trap`
- `pc_plus_4 = pc + 4`, modulo 2^32.
- Address arithmetic is 32-bit unsigned and wraps with no error.

## Timing
- Reset values: `pc = RESET_VEC`, `epc = 0`, `irq_pending = 0`, synchronizer flops = 0. Combinational outputs then follow from these with the inputs.
- Redirect latency: one cycle. A redirect asserted in cycle n appears on `pc` after edge n+1.
- Interrupt latency: 3 edges from the irq rise to `irq_pending = 1` (2 synchronizer flops, then the edge latch). The next eligible cycle after that redirects.
- Branch + trap in the same cycle: the branch wins and `epc` is unchanged. An id_exception is dropped, because the instruction is squashed. An interrupt stays pending.
- Stall + jump in the same cycle: the stall wins. The jump is re-evaluated when the stall drops.
- irq held high is taken once; a new low-to-high transition is needed to retrigger.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). The first fetch after reset release is RESET_VEC.

## Test plan
- Reset: drive reset low mid-run. Expect `pc = 32'h8000_0000` and `epc = 0` asynchronously. First edge after release gives `pc = 32'h8000_0004`.
- Branch: `pc = 32'h0000_0040`, `EX_Branch_EN = 1`, `ConBA = 32'h0000_0100`, `id_jump = 1`. Expect `flush_if_id = 1` and `flush_id_ex = 1`; next `pc = 32'h0000_0100`.
- JR in user mode: `pc = 32'h0000_0010`, `id_jr = 1`, `id_jr_target = 32'h8000_0020`. Expect next `pc = 32'h0000_0020` and `flush_id_ex = 0`.
- Stall: `stall = 1` with `id_jump = 1` for 2 cycles. Expect `pc` held, `hold_if_id = 1`, `flush_id_ex = 1`. When the stall drops, the jump executes.
- Interrupt: user mode `pc = 32'h0000_0200`, `id_pc = 32'h0000_01FC`, pulse irq. Expect `pc = 32'h8000_0008` and `epc = 32'h0000_01FC` after the synchronizer delay. A repeat irq while `pc[31] = 1` stays pending until `pc[31] = 0`.
- Collision: `id_exception = 1` with `irq_pending = 1`. Expect next `pc = 32'h8000_0004` with irq still pending. Repeat with `EX_Branch_EN = 1`: the branch is taken and `epc` is unchanged.
